fetch_unit: RTL and testbench

//  Instruction-fetch stage upstream of the main control decoder. Holds the PC, fetches one 32-bit

---
 rtl/fetch_unit_pkg.sv | 28 ++
 rtl/fetch_unit_next_pc_logic.sv | 27 ++
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: field ranges, FSM states,
// default reset PC and the address-forming helpers used by next-PC logic.
package fetch_unit_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int JIDX_W    = 26;
  localparam int IMM_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] jump_target(input logic [3:0]        seg,
                                              input logic [JIDX_W-1:0] idx);
    return {seg, idx, 2'b00};
  endfunction

  // Sign-extended word offset; adding it to an unsigned PC wraps modulo 2^32.
  function automatic logic [31:0] branch_offset(input logic [IMM_W-1:0] imm);
    return {{14{imm[IMM_W-1]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_next_pc_logic.sv
// Combinational next-PC selection: jump beats a taken branch, else fall through.
module next_pc_logic
  import fetch_unit_pkg::*;
(
  input  logic [31:0]       i_pc_plus4,
  input  logic [JIDX_W-1:0] i_instr_idx,
  input  logic              i_jump,
  input  logic              i_branch,
  input  logic              i_invertzero,
  input  logic              i_alu_zero,
  output logic [31:0]       o_next_pc
);

  logic w_taken;

  assign w_taken = i_branch & (i_alu_zero ^ i_invertzero);

  always_comb begin
    o_next_pc = i_pc_plus4;
    if (i_jump) begin
      o_next_pc = jump_target(i_pc_plus4[31:28], i_instr_idx);
    end else if (w_taken) begin
      o_next_pc = i_pc_plus4 + branch_offset(i_instr_idx[IMM_W-1:0]);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, req/ack instruction fetch, instruction register
// held until retired, and a sticky watchdog on slow fetches.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        advance,
  input  logic        jump,
  input  logic        branch,
  input  logic        invertzero,
  input  logic        alu_zero,
  output logic        fetch_timeout
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LIM  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  fetch_state_e     r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic             r_valid;
  logic             r_req;
  logic             r_tmo;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_next_pc;

  assign w_pc_plus4 = r_pc + 32'd4;

  next_pc_logic u_next_pc (
    .i_pc_plus4   (w_pc_plus4),
    .i_instr_idx  (r_instr[JIDX_W-1:0]),
    .i_jump       (jump),
    .i_branch     (branch),
    .i_invertzero (invertzero),
    .i_alu_zero   (alu_zero),
    .o_next_pc    (w_next_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= 32'h0;
      r_valid <= 1'b0;
      r_req   <= 1'b0;
      r_tmo   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_FETCH;
          r_req   <= 1'b1;
          r_cnt   <= '0;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            r_instr <= imem_rdata;
            r_valid <= 1'b1;
            r_req   <= 1'b0;
            r_state <= ST_VALID;
          end else begin
            // Counter saturates at the limit; the flag itself is sticky until reset.
            if (r_cnt != TMO_LIM) r_cnt <= r_cnt + 1'b1;
            if (r_cnt == TMO_LAST) r_tmo <= 1'b1;
          end
        end
        ST_VALID: begin
          if (advance) begin
            r_pc    <= w_next_pc;
            r_valid <= 1'b0;
            r_req   <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_FETCH;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req      = r_req;
  assign imem_addr     = r_pc;
  assign instr         = r_instr;
  assign instr_valid   = r_valid;
  assign pc            = r_pc;
  assign pc_plus4      = w_pc_plus4;
  assign fetch_timeout = r_tmo;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: handshake timing, next-PC selection, watchdog,
// address wrap and reset-during-fetch.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        advance, jump, branch, invertzero, alu_zero;

  logic        imem_req, instr_valid, fetch_timeout;
  logic [31:0] imem_addr, instr, pc, pc_plus4;

  logic        d2_req, d2_valid, d2_tmo;
  logic [31:0] d2_addr, d2_instr, d2_pc, d2_pc_plus4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(16)) u_dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .advance(advance), .jump(jump), .branch(branch), .invertzero(invertzero),
    .alu_zero(alu_zero), .fetch_timeout(fetch_timeout)
  );

  // Second instance starting at the top of the address space, driven in lockstep.
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT_CYCLES(16)) u_dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req(d2_req), .imem_addr(d2_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(d2_instr), .instr_valid(d2_valid), .pc(d2_pc), .pc_plus4(d2_pc_plus4),
    .advance(advance), .jump(jump), .branch(branch), .invertzero(invertzero),
    .alu_zero(alu_zero), .fetch_timeout(d2_tmo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fetch_word(input string tag, input logic [31:0] w);
    imem_ack   = 1'b1;
    imem_rdata = w;
    tick();
    imem_ack   = 1'b0;
    chk({tag, "_valid"}, {31'h0, instr_valid}, 32'h1);
    chk({tag, "_instr"}, instr, w);
  endtask

  task automatic retire(input string tag, input logic j, input logic b, input logic iz,
                        input logic z, input logic [31:0] exp_addr);
    jump = j; branch = b; invertzero = iz; alu_zero = z;
    advance = 1'b1;
    tick();
    advance = 1'b0; jump = 1'b0; branch = 1'b0; invertzero = 1'b0; alu_zero = 1'b0;
    chk({tag, "_addr"}, imem_addr, exp_addr);
    chk({tag, "_req"}, {31'h0, imem_req}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
    advance = 1'b0; jump = 1'b0; branch = 1'b0; invertzero = 1'b0; alu_zero = 1'b0;
    tick(); tick();
    chk("rst_req",   {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc",    pc, 32'h0);
    chk("rst_pc4",   pc_plus4, 32'h4);
    chk("rst_tmo",   {31'h0, fetch_timeout}, 32'h0);

    // One IDLE bubble, then the first request at the reset PC.
    reset = 1'b0;
    tick();
    chk("t1_req",  {31'h0, imem_req}, 32'h1);
    chk("t1_addr", imem_addr, 32'h0);
    chk("t1_nval", {31'h0, instr_valid}, 32'h0);
    fetch_word("t1", 32'h2001_0005);
    chk("t1_req_lo", {31'h0, imem_req}, 32'h0);
    chk("t1_pc",     pc, 32'h0);
    chk("wrap_pc4",  d2_pc_plus4, 32'h0);
    retire("t1_seq", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0004);
    chk("wrap_addr", d2_addr, 32'h0000_0000);

    // Branch taken / not taken around pc=0x40.
    fetch_word("t2_j", 32'h0800_0010);
    retire("t2_j", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0040);
    fetch_word("t2_beq", 32'h1000_FFFE);
    retire("t2_beq", 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_003C);
    fetch_word("t2_j2", 32'h0800_0010);
    retire("t2_j2", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0040);
    fetch_word("t2_bne", 32'h1000_FFFE);
    retire("t2_bne", 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0044);
    fetch_word("t2_bnet", 32'h1400_0003);
    retire("t2_bnet", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0054);

    // Climb to 0x1000_0000, then jump with branch also asserted.
    fetch_word("t3_jfar", 32'h0BFF_FFFF);
    retire("t3_jfar", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0FFF_FFFC);
    fetch_word("t3_nop", 32'h0000_0000);
    retire("t3_nop", 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000_0000);
    fetch_word("t3_j", 32'h0800_0010);
    retire("t3_jb", 1'b1, 1'b1, 1'b0, 1'b1, 32'h1000_0040);

    // Watchdog trips after 16 ack-less FETCH cycles and stays set.
    for (int i = 0; i < 15; i++) tick();
    chk("t4_tmo15", {31'h0, fetch_timeout}, 32'h0);
    tick();
    chk("t4_tmo16", {31'h0, fetch_timeout}, 32'h1);
    chk("t4_req16", {31'h0, imem_req}, 32'h1);
    tick();
    chk("t4_req17", {31'h0, imem_req}, 32'h1);
    fetch_word("t4_late", 32'hCAFE_0001);
    chk("t4_sticky", {31'h0, fetch_timeout}, 32'h1);
    retire("t4_seq", 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000_0044);
    chk("t4_sticky2", {31'h0, fetch_timeout}, 32'h1);

    reset = 1'b1;
    tick();
    chk("t4_rst_tmo", {31'h0, fetch_timeout}, 32'h0);
    reset = 1'b0;
    tick();
    chk("t4b_addr", imem_addr, 32'h0);
    for (int i = 0; i < 15; i++) tick();
    fetch_word("t4b_ack16", 32'h1234_5678);
    chk("t4b_tmo", {31'h0, fetch_timeout}, 32'h0);

    // Reset during an outstanding fetch; the late ack must be discarded.
    retire("t6_pre", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0004);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_req_rst", {31'h0, imem_req}, 32'h0);
    chk("t6_pc_rst",  pc, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    chk("t6_nval",  {31'h0, instr_valid}, 32'h0);
    chk("t6_instr", instr, 32'h0);
    chk("t6_req",   {31'h0, imem_req}, 32'h1);
    chk("t6_addr",  imem_addr, 32'h0);
    advance = 1'b1; jump = 1'b1;
    tick();
    advance = 1'b0; jump = 1'b0;
    chk("t6_adv_pc",  pc, 32'h0);
    chk("t6_adv_req", {31'h0, imem_req}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
